// File: rtl/rrp_mult_sched.sv
// Round-robin issue scheduler in front of a shared, non-stallable rRp_mult pipeline.
// Request ids ride a valid/tag shift register. Products collect in a credit-protected response FIFO.
module rrp_mult_sched #(
  parameter int WIDTH    = 7,
  parameter int RADIX    = 2,
  parameter int NREQ     = 4,
  parameter int MULT_LAT = 11,
  parameter int DEPTH    = 4,
  localparam int D  = $clog2(RADIX) + 1,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*D*WIDTH-1:0]      req_x,
  input  logic [NREQ*D*WIDTH-1:0]      req_y,
  output logic [NREQ-1:0]              req_ready,
  output logic [D*WIDTH-1:0]           mult_x,
  output logic [D*WIDTH-1:0]           mult_y,
  input  logic [D*(2*WIDTH+1)-1:0]     mult_p,
  output logic                         rsp_valid,
  output logic [IW-1:0]                rsp_id,
  output logic [D*(2*WIDTH+1)-1:0]     rsp_p,
  input  logic                         rsp_ready,
  output logic                         busy
);
  localparam int DW = D * WIDTH;
  localparam int PW = D * (2 * WIDTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  // The tag pipe has one stage more than MULT_LAT. Stage 0 lines up with mult_x, and the last
  // stage lines up with the cycle in which mult_p carries that product.
  localparam int NS = MULT_LAT + 1;

  logic [DW-1:0] x_arr [NREQ];
  logic [DW-1:0] y_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign x_arr[gi] = req_x[gi*DW +: DW];
      assign y_arr[gi] = req_y[gi*DW +: DW];
    end
  endgenerate

  logic [IW-1:0] last_grant_reg;
  logic [CW-1:0] fifo_count_reg, inflight_reg;
  logic [AW-1:0] head_reg, tail_reg;
  logic [PW-1:0] mem_p [DEPTH];
  logic [IW-1:0] mem_id [DEPTH];
  logic [NS-1:0] v_reg;
  logic [IW-1:0] id_reg [NS];
  logic [DW-1:0] mult_x_reg, mult_y_reg;
  logic          busy_reg;

  logic          issue_ok, grant_found, xfer, push, pop;
  logic [IW-1:0] grant_idx;
  logic [CW:0]   occ;
  int            cand;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    occ         = {1'b0, fifo_count_reg} + {1'b0, inflight_reg};
    issue_ok    = !reset && (occ < (CW+1)'(DEPTH));
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(last_grant_reg) + 1 + k) % NREQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
    req_ready = '0;
    if (issue_ok && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign xfer      = |(req_valid & req_ready);
  assign push      = v_reg[NS-1];
  assign rsp_valid = (fifo_count_reg != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_p     = mem_p[head_reg];
  assign rsp_id    = mem_id[head_reg];
  assign mult_x    = mult_x_reg;
  assign mult_y    = mult_y_reg;
  assign busy      = busy_reg;

  // Idle cycles issue zeros so that the free-running multiplier never sees stale operands.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mult_x_reg     <= '0;
      mult_y_reg     <= '0;
      last_grant_reg <= IW'(NREQ - 1);
    end else if (xfer) begin
      mult_x_reg     <= x_arr[grant_idx];
      mult_y_reg     <= y_arr[grant_idx];
      last_grant_reg <= grant_idx;
    end else begin
      mult_x_reg     <= '0;
      mult_y_reg     <= '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v_reg <= '0;
      for (int s = 0; s < NS; s++) id_reg[s] <= '0;
    end else begin
      v_reg     <= {v_reg[NS-2:0], xfer};
      id_reg[0] <= grant_idx;
      for (int s = 1; s < NS; s++) id_reg[s] <= id_reg[s-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight_reg   <= '0;
      fifo_count_reg <= '0;
      head_reg       <= '0;
      tail_reg       <= '0;
      busy_reg       <= 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        mem_p[e]  <= '0;
        mem_id[e] <= '0;
      end
    end else begin
      case ({xfer, push})
        2'b10:   inflight_reg <= inflight_reg + 1'b1;
        2'b01:   inflight_reg <= inflight_reg - 1'b1;
        default: inflight_reg <= inflight_reg;
      endcase
      if (push) begin
        mem_p[tail_reg]  <= mult_p;
        mem_id[tail_reg] <= id_reg[NS-1];
        tail_reg         <= ptr_inc(tail_reg);
      end
      if (pop) head_reg <= ptr_inc(head_reg);
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
        2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
        default: fifo_count_reg <= fifo_count_reg;
      endcase
      busy_reg <= (inflight_reg != '0) || (fifo_count_reg != '0);
    end
  end
endmodule

// File: tb/tb_rrp_mult_sched.sv
// Bench for rrp_mult_sched. It uses a behavioural signed-digit multiplier, and a scoreboard fed at
// each transfer and drained at each response pop.
module tb_rrp_mult_sched;
  localparam int WIDTH = 7, RADIX = 2, NREQ = 4, MULT_LAT = 11, DEPTH = 4;
  localparam int D  = $clog2(RADIX) + 1;
  localparam int IW = 2;
  localparam int DW = D * WIDTH;
  localparam int PW = D * (2 * WIDTH + 1);

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*DW-1:0]   req_x = '0, req_y = '0;
  logic [NREQ-1:0]      req_ready;
  logic [DW-1:0]        mult_x, mult_y;
  logic [PW-1:0]        mult_p;
  logic                 rsp_valid, busy;
  logic [IW-1:0]        rsp_id;
  logic [PW-1:0]        rsp_p;
  logic                 rsp_ready = 1'b0;

  always #5 clock = ~clock;

  rrp_mult_sched #(.WIDTH(WIDTH), .RADIX(RADIX), .NREQ(NREQ), .MULT_LAT(MULT_LAT), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .mult_x(mult_x), .mult_y(mult_y), .mult_p(mult_p),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p), .rsp_ready(rsp_ready), .busy(busy)
  );

  // Operand digit k sits at bits [k*D +: D] and weighs 2^-(k+1). Product digit k weighs 2^-k.
  // Digits are two's complement in {-1, 0, 1}.
  function automatic longint dec(input logic [DW-1:0] v);
    longint acc = 0;
    for (int k = 0; k < WIDTH; k++)
      acc += longint'($signed(v[k*D +: D])) * (longint'(1) << (WIDTH - 1 - k));
    return acc;
  endfunction

  function automatic logic [PW-1:0] mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint p = dec(a) * dec(b);
    longint mag = (p < 0) ? -p : p;
    logic [PW-1:0] r = '0;
    for (int k = 0; k <= 2 * WIDTH; k++)
      if (mag[2*WIDTH-k]) r[k*D +: D] = (p < 0) ? {D{1'b1}} : D'(1);
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_op();
    logic [DW-1:0] r = '0;
    for (int k = 0; k < WIDTH; k++)
      case ($urandom_range(0, 2))
        0:       r[k*D +: D] = D'(0);
        1:       r[k*D +: D] = D'(1);
        default: r[k*D +: D] = {D{1'b1}};
      endcase
    return r;
  endfunction

  logic [PW-1:0] mpipe [MULT_LAT];
  always @(posedge clock) begin
    mpipe[0] <= mul(mult_x, mult_y);
    for (int k = 1; k < MULT_LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mult_p = mpipe[MULT_LAT-1];

  typedef struct { logic [IW-1:0] id; logic [PW-1:0] p; } exp_t;
  exp_t sb[$];
  int   grant_log[$];
  int   errors = 0, checks = 0, cyc = 0;
  int   xfer_count = 0, pop_count = 0, valid_seen = 0;
  int   pending [NREQ];
  logic [DW-1:0] opx [NREQ];
  logic [DW-1:0] opy [NREQ];
  logic [NREQ-1:0] xfer_last = '0;

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]       = pending[i] > 0;
      req_x[i*DW +: DW]  = opx[i];
      req_y[i*DW +: DW]  = opy[i];
    end
  endtask

  // Requester model: after an accepted transfer, it presents fresh operands while it has work left.
  always @(posedge clock) begin
    cyc++;
    #1;
    for (int i = 0; i < NREQ; i++)
      if (xfer_last[i]) begin
        pending[i]--;
        opx[i] = rnd_op();
        opy[i] = rnd_op();
      end
    xfer_last = '0;
    drive_inputs();
  end

  // The monitor samples mid-cycle what the coming edge will transfer and pop.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      xfer_last = '0;
    end else begin
      xfer_last = req_valid & req_ready;
      if ($countones(req_ready) > 1) begin
        errors++;
        $display("FAIL onehot: req_ready=%b required at most one bit", req_ready);
      end
      for (int i = 0; i < NREQ; i++)
        if (xfer_last[i]) begin
          sb.push_back('{IW'(i), mul(req_x[i*DW +: DW], req_y[i*DW +: DW])});
          grant_log.push_back(i);
          xfer_count++;
        end
      if (dut.push) begin
        checks++;
        if (dut.fifo_count_reg >= DEPTH) begin
          errors++;
          $display("FAIL overflow: push with count=%0d required < %0d", dut.fifo_count_reg, DEPTH);
        end
      end
      if (rsp_valid) valid_seen++;
      if (rsp_valid && rsp_ready) begin
        checks++;
        pop_count++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: id=%0d p=%h with empty scoreboard", rsp_id, rsp_p);
        end else begin
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_p !== e.p) begin
            errors++;
            $display("FAIL rsp_data: id=%0d p=%h required id=%0d p=%h", rsp_id, rsp_p, e.id, e.p);
          end
        end
      end
    end
  end

  task automatic apply_reset();
    reset = 1'b1;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) pending[i] = 0;
    drive_inputs();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    grant_log.delete();
    xfer_count = 0;
    pop_count = 0;
    valid_seen = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      pending[i] = 1;
      opx[i] = rnd_op();
      opy[i] = rnd_op();
    end
    drive_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    checks += 7;
    if (req_ready !== '0)  begin errors++; $display("FAIL reset_req_ready: %b required 0", req_ready); end
    if (mult_x !== '0)     begin errors++; $display("FAIL reset_mult_x: %h required 0", mult_x); end
    if (mult_y !== '0)     begin errors++; $display("FAIL reset_mult_y: %h required 0", mult_y); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: %b required 0", rsp_valid); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: %b required 0", busy); end
    if (rsp_id !== '0)     begin errors++; $display("FAIL reset_rsp_id: %0d required 0", rsp_id); end
    if (rsp_p !== '0)      begin errors++; $display("FAIL reset_rsp_p: %h required 0", rsp_p); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    int n = -1, m = -1;
    apply_reset();
    opx[2] = DW'(1);
    opy[2] = DW'(1);
    pending[2] = 1;
    drive_inputs();
    for (int c = 0; c < 20 && n < 0; c++) begin
      @(negedge clock); #1;
      if (req_valid[2] && req_ready[2]) n = cyc;
    end
    checks++;
    if (n < 0) begin errors++; $display("FAIL single_grant: no transfer within 20 cycles"); end
    for (int c = 0; c < 40 && m < 0; c++) begin
      @(negedge clock); #1;
      if (rsp_valid) m = cyc;
    end
    checks += 3;
    if (m - (n + 1) != MULT_LAT + 1) begin
      errors++; $display("FAIL single_latency: %0d edges required %0d", m - (n + 1), MULT_LAT + 1);
    end
    if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_id: %0d required 2", rsp_id); end
    if (rsp_p !== 30'h10) begin errors++; $display("FAIL single_p: %h required 0000010 (0.25)", rsp_p); end
    @(posedge clock); #2;
    rsp_ready = 1'b1;
    repeat (20) @(posedge clock);
    #2;
    checks++;
    if (pop_count != 1) begin errors++; $display("FAIL single_count: %0d responses required 1", pop_count); end
    $display("test_single: transfer edge %0d, response edge %0d", n + 1, m);
  endtask

  task automatic test_round_robin();
    apply_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) pending[i] = 8;
    drive_inputs();
    for (int c = 0; c < 800 && pop_count < 32; c++) @(posedge clock);
    #2;
    checks += 2;
    if (pop_count != 32) begin errors++; $display("FAIL rr_count: %0d responses required 32", pop_count); end
    if (grant_log.size() != 32) begin errors++; $display("FAIL rr_grants: %0d grants required 32", grant_log.size()); end
    for (int k = 0; k < grant_log.size() && k < 32; k++) begin
      checks++;
      if (grant_log[k] != k % NREQ) begin
        errors++; $display("FAIL rr_order[%0d]: grant %0d required %0d", k, grant_log[k], k % NREQ);
      end
    end
    $display("test_round_robin: %0d grants, %0d responses", grant_log.size(), pop_count);
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int i = 0; i < NREQ; i++) pending[i] = 3;
    drive_inputs();
    repeat (30) @(posedge clock);
    @(negedge clock); #1;
    checks += 3;
    if (xfer_count != DEPTH) begin errors++; $display("FAIL bp_transfers: %0d required %0d", xfer_count, DEPTH); end
    if (req_ready !== '0) begin errors++; $display("FAIL bp_ready_low: %b required 0", req_ready); end
    if (dut.fifo_count_reg != DEPTH) begin errors++; $display("FAIL bp_fill: %0d required %0d", dut.fifo_count_reg, DEPTH); end
    @(posedge clock); #2;
    rsp_ready = 1'b1;
    @(negedge clock); #1;
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL bp_same_cycle_credit: %b required 0", req_ready); end
    @(posedge clock); #2;
    rsp_ready = 1'b0;
    @(negedge clock); #1;
    checks += 2;
    if ($countones(req_ready) != 1) begin errors++; $display("FAIL bp_credit_return: %b required one-hot", req_ready); end
    if (xfer_count != DEPTH + 1) begin errors++; $display("FAIL bp_one_issue: %0d required %0d", xfer_count, DEPTH + 1); end
    @(posedge clock); #2;
    rsp_ready = 1'b1;
    for (int c = 0; c < 400 && pop_count < 12; c++) @(posedge clock);
    #2;
    checks += 2;
    if (pop_count != 12) begin errors++; $display("FAIL bp_drain: %0d responses required 12", pop_count); end
    if (sb.size() != 0) begin errors++; $display("FAIL bp_leftover: %0d expected entries remain", sb.size()); end
    $display("test_backpressure: %0d transfers, %0d responses", xfer_count, pop_count);
  endtask

  task automatic test_push_pop();
    int c;
    apply_reset();
    pending[0] = 3;
    drive_inputs();
    for (c = 0; c < 40 && dut.fifo_count_reg != 2; c++) begin
      @(posedge clock); #2;
    end
    checks++;
    if (c >= 40) begin errors++; $display("FAIL pp_reach2: FIFO never held 2 entries"); end
    rsp_ready = 1'b1;
    @(posedge clock); #2;
    checks++;
    if (dut.fifo_count_reg != 2) begin errors++; $display("FAIL pp_count: %0d required 2", dut.fifo_count_reg); end
    for (c = 0; c < 40 && pop_count < 3; c++) @(posedge clock);
    #2;
    checks++;
    if (pop_count != 3 || sb.size() != 0) begin
      errors++; $display("FAIL pp_drain: %0d responses required 3, %0d left", pop_count, sb.size());
    end
    $display("test_push_pop: %0d responses", pop_count);
  endtask

  task automatic test_reset_midflight();
    int c;
    apply_reset();
    rsp_ready = 1'b1;
    pending[0] = 3;
    drive_inputs();
    for (c = 0; c < 20 && xfer_count < 3; c++) begin
      @(posedge clock); #2;
    end
    #1;
    reset = 1'b1;
    #1;
    checks += 5;
    if (mult_x !== '0 || mult_y !== '0) begin errors++; $display("FAIL mid_mult: x=%h y=%h required 0", mult_x, mult_y); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid: %b required 0", rsp_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: %b required 0", busy); end
    if (req_ready !== '0) begin errors++; $display("FAIL mid_req_ready: %b required 0", req_ready); end
    if (rsp_p !== '0 || rsp_id !== '0) begin errors++; $display("FAIL mid_rsp: id=%0d p=%h required 0", rsp_id, rsp_p); end
    @(posedge clock); #2;
    reset = 1'b0;
    valid_seen = 0;
    pop_count = 0;
    repeat (MULT_LAT + 6) @(posedge clock);
    #2;
    checks++;
    if (valid_seen != 0 || pop_count != 0) begin
      errors++; $display("FAIL mid_discard: %0d valid cycles, %0d responses, required 0", valid_seen, pop_count);
    end
    $display("test_reset_midflight: issued %0d before reset", xfer_count);
  endtask

  task automatic test_wrap();
    int c;
    apply_reset();
    rsp_ready = 1'b1;
    pending[1] = 3 * DEPTH + 1;
    drive_inputs();
    for (c = 0; c < 800 && pop_count < 3 * DEPTH + 1; c++) begin
      @(posedge clock); #2;
    end
    checks += 4;
    if (pop_count != 3 * DEPTH + 1) begin errors++; $display("FAIL wrap_count: %0d required %0d", pop_count, 3 * DEPTH + 1); end
    if (busy !== 1'b1) begin errors++; $display("FAIL wrap_busy_hold: %b required 1 at last pop", busy); end
    @(posedge clock); #2;
    if (busy !== 1'b0) begin errors++; $display("FAIL wrap_busy_fall: %b required 0", busy); end
    if (sb.size() != 0) begin errors++; $display("FAIL wrap_leftover: %0d expected entries remain", sb.size()); end
    $display("test_wrap: %0d responses", pop_count);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      pending[i] = 0;
      opx[i] = '0;
      opy[i] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_push_pop();
    test_reset_midflight();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
